// File: rtl/ucsbece154b_prefetch_buffer_pkg.sv
// Shared types and constants for the ucsbece154b instruction prefetch stream buffer.
package ucsbece154b_prefetch_pkg;

    localparam int WORD_BYTES    = 4;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } pf_state_e;

endpackage

// File: rtl/ucsbece154b_prefetch_buffer_if.sv
// Instruction memory read port: in-order single-word requests, one response word each.
interface ucsbece154b_prefetch_buffer_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ready_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ready_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/ucsbece154b_prefetch_buffer_fifo.sv
// DEPTH-entry circular word FIFO; clear wins over push/pop, pointers wrap naturally.
module ucsbece154b_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [31:0]   wdata_i,
    input  logic          pop_i,
    output logic [31:0]   rdata_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DEPTH-1:0][31:0] mem_q;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q,  count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ucsbece154b_prefetch_buffer.sv
// Sequential prefetch stream buffer feeding the F stage; serves head hits in zero cycles
// and restarts on redirect, dropping responses that belong to the abandoned stream.
module ucsbece154b_prefetch_buffer
    import ucsbece154b_prefetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    ucsbece154b_prefetch_buffer_if.master mem
);

    localparam logic [31:0] STEP    = 32'(WORD_BYTES);
    localparam logic [CW:0] BUDGET  = (CW+1)'(DEPTH);

    pf_state_e     state_q, state_d;
    logic [31:0]   head_addr_q, head_addr_d;
    logic [31:0]   next_addr_q, next_addr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic          redirect, hit, issue, mem_req;
    logic          rsp_live, rsp_drop;
    logic [31:0]   target;
    logic [31:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [CW:0]   budget_used;

    // A fetch in IDLE, a fetch off the head, or a flush all restart the stream.
    assign redirect = flush_i | (fetch_req_i & ((state_q == IDLE) | (fetch_pc_i != head_addr_q)));
    assign target   = flush_i ? flush_pc_i : fetch_pc_i;
    assign hit      = (state_q == STREAM) & ~flush_i & fetch_req_i
                    & (fetch_pc_i == head_addr_q) & ~fifo_empty;

    // Words still owed to a dead stream do not reserve FIFO space.
    assign budget_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign mem_req     = (state_q == STREAM) & ~redirect & (budget_used < BUDGET);
    assign issue       = mem_req & mem.mem_ready_i;

    assign rsp_drop = mem.mem_rvalid_i & (discard_q != '0);
    assign rsp_live = mem.mem_rvalid_i & (discard_q == '0);

    assign fetch_valid_o  = hit;
    assign fetch_instr_o  = hit ? fifo_rdata : 32'h0;
    assign mem.mem_req_o  = mem_req;
    assign mem.mem_addr_o = next_addr_q;

    ucsbece154b_prefetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (redirect),
        .push_i  (rsp_live),
        .wdata_i (mem.mem_rdata_i),
        .pop_i   (hit),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        head_addr_d   = head_addr_q;
        next_addr_d   = next_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect) begin
            state_d       = STREAM;
            head_addr_d   = target;
            next_addr_d   = target;
            outstanding_d = '0;
            // Everything still in flight is stale except a word landing right now.
            discard_d     = discard_q + outstanding_q - CW'(mem.mem_rvalid_i);
        end else begin
            if (hit)   head_addr_d = head_addr_q + STEP;
            if (issue) next_addr_d = next_addr_q + STEP;
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_live);
            discard_d     = discard_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            head_addr_q   <= '0;
            next_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            head_addr_q   <= head_addr_d;
            next_addr_q   <= next_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_prefetch_buffer.sv
// Bench for the prefetch stream buffer: in-order latency memory plus a queue-based reference.
module tb_ucsbece154b_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_i, flush_i;
    logic [31:0] fetch_pc_i, flush_pc_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;

    ucsbece154b_prefetch_buffer_if mif ();

    ucsbece154b_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req_i   (fetch_req_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_instr_o (fetch_instr_o),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .mem           (mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } rd_t;

    rd_t         mq[$];       // reads in flight at the memory, oldest first
    logic [31:0] fq[$];       // words the buffer should be holding
    logic [31:0] issued[$];
    bit          m_stream;
    logic [31:0] m_head, m_next;
    int          cyc, lat, rdy_pct;
    int          n_chk, n_err;
    logic        o_valid, o_req;
    logic [31:0] o_instr, o_addr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive memory side, check outputs at negedge, advance model over the edge.
    task automatic cycle();
        bit          redir, hit, ereq, rv;
        int          live;
        logic [31:0] tgt;
        rd_t         e;
        mif.mem_ready_i = ($urandom_range(99) < rdy_pct);
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        mif.mem_rvalid_i = rv;
        mif.mem_rdata_i  = rv ? memword(mq[0].addr) : $urandom;
        @(negedge clk);
        redir = flush_i || (fetch_req_i && (!m_stream || fetch_pc_i != m_head));
        tgt   = flush_i ? flush_pc_i : fetch_pc_i;
        hit   = m_stream && !flush_i && fetch_req_i && (fetch_pc_i == m_head) && (fq.size() > 0);
        live  = 0;
        foreach (mq[i]) if (!mq[i].stale) live++;
        ereq  = m_stream && !redir && (fq.size() + live < DEPTH);
        o_valid = fetch_valid_o;
        o_instr = fetch_instr_o;
        o_req   = mif.mem_req_o;
        o_addr  = mif.mem_addr_o;
        chk("fetch_valid", fetch_valid_o, hit);
        chk("fetch_instr", fetch_instr_o, hit ? fq[0] : 32'h0);
        chk("mem_req", mif.mem_req_o, ereq);
        if (ereq) chk("mem_addr", mif.mem_addr_o, m_next);
        if (rv) begin
            e = mq.pop_front();
            if (!e.stale && !redir) fq.push_back(memword(e.addr));
        end
        if (redir) begin
            fq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_stream = 1'b1;
            m_head   = tgt;
            m_next   = tgt;
        end else begin
            if (hit) begin
                void'(fq.pop_front());
                m_head += 32'd4;
            end
            if (ereq && mif.mem_ready_i) m_next += 32'd4;
        end
        if (mif.mem_req_o && mif.mem_ready_i) begin
            e.addr  = mif.mem_addr_o;
            e.due   = cyc + lat;
            e.stale = 1'b0;
            mq.push_back(e);
            issued.push_back(mif.mem_addr_o);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        fetch_req_i  = 1'b0;
        flush_i      = 1'b0;
        fetch_pc_i   = 32'h0;
        flush_pc_i   = 32'h0;
        mif.mem_ready_i  = 1'b0;
        mif.mem_rvalid_i = 1'b0;
        mif.mem_rdata_i  = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        fq.delete();
        issued.delete();
        m_stream = 1'b0;
        m_head   = 32'h0;
        m_next   = 32'h0;
        chk("rst_valid", fetch_valid_o, 32'h0);
        chk("rst_instr", fetch_instr_o, 32'h0);
        chk("rst_req", mif.mem_req_o, 32'h0);
        chk("rst_addr", mif.mem_addr_o, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, hits, r;
        n_chk = 0; n_err = 0; cyc = 0; lat = 2; rdy_pct = 100;

        // Cold start, latency 2, then a sustained one-per-cycle hit stream.
        do_reset();
        fetch_req_i = 1'b1; fetch_pc_i = 32'h00010054;
        k = -1;
        for (int i = 0; i < 20 && k < 0; i++) begin
            cycle();
            if (o_valid) k = i;
        end
        chk("first_hit_lat", k, 32'd4);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_valid) fetch_pc_i += 32'd4;
            cycle();
            if (o_valid) hits++;
        end
        chk("stream_hits", hits, 32'd4);

        // Memory never ready: request held stable; then fill to DEPTH with fetch idle.
        do_reset();
        rdy_pct = 0;
        fetch_req_i = 1'b1; fetch_pc_i = 32'h00002000;
        cycle();
        fetch_req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("stall_req", o_req, 32'd1);
            chk("stall_addr", o_addr, 32'h00002000);
        end
        rdy_pct = 100;
        repeat (8) cycle();
        chk("full_req", o_req, 32'd0);
        chk("full_issued", issued.size(), 32'd4);

        // Flush with three reads in flight; stale words must never be served.
        do_reset();
        lat = 4;
        fetch_req_i = 1'b1; fetch_pc_i = 32'h00010100;
        cycle();
        fetch_req_i = 1'b0;
        repeat (3) cycle();
        chk("inflight", issued.size(), 32'd3);
        flush_i = 1'b1; flush_pc_i = 32'h00010020;
        cycle();
        flush_i = 1'b0;
        fetch_req_i = 1'b1; fetch_pc_i = 32'h00010020;
        k = -1;
        for (int i = 0; i < 30 && k < 0; i++) begin
            cycle();
            if (o_valid) k = i;
        end
        chk("flush_lat", k, 32'd5);
        chk("flush_first_instr", o_instr, memword(32'h00010020));

        // Fetch off the head: implicit redirect and restart.
        do_reset();
        lat = 1;
        fetch_req_i = 1'b1; fetch_pc_i = 32'h00010028;
        for (int i = 0; i < 20 && fetch_pc_i != 32'h00010030; i++) begin
            cycle();
            if (o_valid) fetch_pc_i += 32'd4;
        end
        fetch_pc_i = 32'h00010040;
        cycle();
        chk("implicit_redir_valid", o_valid, 32'd0);
        fetch_req_i = 1'b0;
        cycle();
        chk("restart_req", o_req, 32'd1);
        chk("restart_addr", o_addr, 32'h00010040);

        // Flush and a head fetch in the same cycle: flush wins.
        do_reset();
        fetch_req_i = 1'b1; fetch_pc_i = 32'h00010200;
        cycle();
        fetch_req_i = 1'b0;
        repeat (6) cycle();
        fetch_req_i = 1'b1; fetch_pc_i = 32'h00010200;
        flush_i = 1'b1; flush_pc_i = 32'h00000100;
        cycle();
        chk("flush_prio_valid", o_valid, 32'd0);
        flush_i = 1'b0; fetch_pc_i = 32'h00000100;
        k = -1;
        for (int i = 0; i < 20 && k < 0; i++) begin
            cycle();
            if (o_valid) k = i;
        end
        chk("flush_prio_instr", o_instr, memword(32'h00000100));

        // Address wrap, then reset mid-stream.
        do_reset();
        lat = 2;
        fetch_req_i = 1'b1; fetch_pc_i = 32'hFFFFFFF8;
        cycle();
        fetch_req_i = 1'b0;
        repeat (4) cycle();
        chk("wrap_cnt", issued.size() >= 3, 32'd1);
        if (issued.size() >= 3) begin
            chk("wrap0", issued[0], 32'hFFFFFFF8);
            chk("wrap1", issued[1], 32'hFFFFFFFC);
            chk("wrap2", issued[2], 32'h00000000);
        end
        do_reset();
        cycle();
        chk("idle_after_rst", o_req, 32'd0);

        // Randomized traffic.
        for (int seg = 0; seg < 8; seg++) begin
            lat     = $urandom_range(1, 3);
            rdy_pct = $urandom_range(30, 100);
            for (int i = 0; i < 250; i++) begin
                r = $urandom_range(99);
                flush_i     = 1'b0;
                fetch_req_i = 1'b1;
                fetch_pc_i  = m_head;
                if (r < 4) begin
                    flush_i    = 1'b1;
                    flush_pc_i = 32'h00400000 + (32'($urandom_range(0, 63)) << 2);
                end else if (r < 8) begin
                    fetch_pc_i = m_head + (32'($urandom_range(1, 8)) << 2);
                end else if (r < 20) begin
                    fetch_req_i = 1'b0;
                end
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
